// File: rtl/ghost_motion_ctrl_pkg.sv
// Shared types, register map and helpers for the ghost motion sequencer.
package ghost_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_C
  } state_t;

  localparam logic [1:0] REG_BYPASS = 2'b00;
  localparam logic [1:0] REG_X0     = 2'b01;
  localparam logic [1:0] REG_Y0     = 2'b10;
  localparam logic [1:0] REG_CTRL   = 2'b11;

  localparam int REG_SPACE_BIT = 13;
  localparam int ADDR_W        = 14;
  localparam int DATA_W        = 32;
  localparam int POS_W         = 11;

  // Slot address of a sprite register: register space bit plus offset.
  function automatic logic [ADDR_W-1:0] reg_addr(input logic [1:0] off);
    logic [ADDR_W-1:0] a;
    a                = '0;
    a[REG_SPACE_BIT] = 1'b1;
    a[1:0]           = off;
    return a;
  endfunction

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// Video slot bus towards a sprite core; used for both CPU input and sprite output.
interface ghost_motion_ctrl_if;
  import ghost_pkg::*;

  logic              cs;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/ghost_motion_ctrl_axis_step.sv
// One axis of motion: advance by the velocity and bounce off 0 / limit.
module ghost_axis_step #(
  parameter int VEL_W = 4
) (
  input  logic        [10:0]      pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic        [10:0]      limit,
  output logic        [10:0]      next_pos,
  output logic signed [VEL_W-1:0] next_vel
);
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

  logic signed [VEL_W-1:0] vel_eff;
  logic signed [11:0]      sum;

  always_comb begin
    // The most-negative velocity has no negation; it behaves as max positive.
    vel_eff  = (vel == VEL_MIN) ? VEL_MAX : vel;
    sum      = $signed({1'b0, pos}) + $signed({{(12-VEL_W){vel_eff[VEL_W-1]}}, vel_eff});
    next_pos = sum[10:0];
    next_vel = vel_eff;
    if (sum < 12'sd0) begin
      next_pos = '0;
      next_vel = -vel_eff;
    end else if (sum > $signed({1'b0, limit})) begin
      next_pos = limit;
      next_vel = -vel_eff;
    end
  end
endmodule

// File: rtl/ghost_motion_ctrl.sv
// Per-frame ghost sprite mover/animator; shares the sprite slot bus with the CPU,
// which always wins, and tracks CPU position writes so motion stays coherent.
module ghost_motion_ctrl
  import ghost_pkg::*;
#(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int SPRITE_W   = 16,
  parameter int VEL_W      = 4,
  parameter int ANIM_DIV_W = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_start,
  input  logic                         auto_en,
  input  logic signed [VEL_W-1:0]      vx_init,
  input  logic signed [VEL_W-1:0]      vy_init,
  input  logic        [ANIM_DIV_W-1:0] anim_div,
  input  logic        [2:0]            ghost_color,
  ghost_motion_ctrl_if.slave           cpu,
  ghost_motion_ctrl_if.master          spr,
  output logic                         busy,
  output logic                         overrun
);
  state_t                  state_reg, state_next;
  logic [2*POS_W-1:0]      wr_pos_flat;
  logic [ANIM_DIV_W-1:0]   div_cnt_reg;
  logic [1:0]              anim_frame_reg;
  logic                    anim_tick_reg;
  logic                    vel_load_reg;
  logic                    auto_en_d_reg;
  logic                    overrun_reg;
  logic                    cpu_wr;
  logic                    eng_wr;
  logic [ADDR_W-1:0]       eng_addr;
  logic [DATA_W-1:0]       eng_data;

  assign cpu_wr = cpu.cs & cpu.write;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [POS_W-1:0] LIMIT = (gi == 0) ? POS_W'(H_MAX - SPRITE_W)
                                                     : POS_W'(V_MAX - SPRITE_W);
      localparam logic [1:0]       OFF   = (gi == 0) ? REG_X0 : REG_Y0;

      logic [POS_W-1:0]        pos_reg, wr_pos_reg, nxt_pos;
      logic signed [VEL_W-1:0] vel_reg, nxt_vel, vel_init;
      logic                    cpu_hit;

      assign vel_init = (gi == 0) ? vx_init : vy_init;
      assign cpu_hit  = cpu_wr & cpu.addr[REG_SPACE_BIT] & (cpu.addr[1:0] == OFF);
      assign wr_pos_flat[gi*POS_W +: POS_W] = wr_pos_reg;

      ghost_axis_step #(.VEL_W(VEL_W)) u_step (
        .pos      (pos_reg),
        .vel      (vel_reg),
        .limit    (LIMIT),
        .next_pos (nxt_pos),
        .next_vel (nxt_vel)
      );

      // The write-out copy is separate so a CPU write during WR_X/WR_Y only
      // redirects the base for the next frame, not the value in flight.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pos_reg    <= '0;
          wr_pos_reg <= '0;
          vel_reg    <= '0;
        end else begin
          if (state_reg == ST_IDLE && (!auto_en || vel_load_reg))
            vel_reg <= vel_init;
          else if (state_reg == ST_CALC)
            vel_reg <= nxt_vel;
          if (state_reg == ST_CALC)
            wr_pos_reg <= nxt_pos;
          if (cpu_hit)
            pos_reg <= cpu.wr_data[POS_W-1:0];
          else if (state_reg == ST_CALC)
            pos_reg <= nxt_pos;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (frame_start && auto_en) state_next = ST_CALC;
      ST_CALC: state_next = ST_WR_X;
      ST_WR_X: if (!cpu_wr) state_next = ST_WR_Y;
      ST_WR_Y: if (!cpu_wr) state_next = anim_tick_reg ? ST_WR_C : ST_IDLE;
      ST_WR_C: if (!cpu_wr) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_wr   = 1'b0;
    eng_addr = '0;
    eng_data = '0;
    case (state_reg)
      ST_WR_X: begin
        eng_wr   = 1'b1;
        eng_addr = reg_addr(REG_X0);
        eng_data = DATA_W'(wr_pos_flat[POS_W-1:0]);
      end
      ST_WR_Y: begin
        eng_wr   = 1'b1;
        eng_addr = reg_addr(REG_Y0);
        eng_data = DATA_W'(wr_pos_flat[2*POS_W-1:POS_W]);
      end
      ST_WR_C: begin
        eng_wr   = 1'b1;
        eng_addr = reg_addr(REG_CTRL);
        eng_data = DATA_W'({ghost_color, anim_frame_reg});
      end
      default: ;
    endcase
    if (cpu_wr) begin
      spr.cs      = cpu.cs;
      spr.write   = cpu.write;
      spr.addr    = cpu.addr;
      spr.wr_data = cpu.wr_data;
    end else begin
      spr.cs      = eng_wr;
      spr.write   = eng_wr;
      spr.addr    = eng_addr;
      spr.wr_data = eng_data;
    end
  end

  // vel_load_reg makes the first cycle after reset release pick up the
  // velocity inputs even when the engine is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg    <= '0;
      anim_frame_reg <= '0;
      anim_tick_reg  <= 1'b0;
      vel_load_reg   <= 1'b1;
      auto_en_d_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      vel_load_reg  <= 1'b0;
      auto_en_d_reg <= auto_en;
      if (state_reg == ST_CALC) begin
        if (div_cnt_reg == anim_div) begin
          div_cnt_reg    <= '0;
          anim_frame_reg <= anim_frame_reg + 2'd1;
          anim_tick_reg  <= 1'b1;
        end else begin
          div_cnt_reg    <= div_cnt_reg + ANIM_DIV_W'(1);
          anim_tick_reg  <= 1'b0;
        end
      end
      if (auto_en_d_reg && !auto_en)
        overrun_reg <= 1'b0;
      else if (frame_start && state_reg != ST_IDLE)
        overrun_reg <= 1'b1;
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign overrun = overrun_reg;
endmodule

// File: doc/ghost_motion_ctrl.md
Name: ghost_motion_ctrl

Overview:
- Autonomous per-frame motion and animation sequencer for one ghost sprite core.
- Once per video frame it moves the sprite by a signed velocity and bounces it off the screen edges.
- It advances the animation frame every ANIM_DIV_W-selected number of frames, then writes x0, y0 and ctrl into the sprite core over its video slot bus.
- The slot bus is shared with the CPU. CPU writes pass through with absolute priority, and the engine's internal position is kept coherent with CPU writes.

Parameters:
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in pixels
- SPRITE_W, 16, sprite width and height in pixels
- VEL_W, 4, width of the signed per-frame velocity
- ANIM_DIV_W, 4, width of the animation frame divider

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame's vertical blank
- auto_en  in  1  engine enable; when 0, only CPU traffic reaches the sprite
- vx_init  in  VEL_W  signed x velocity, loaded at reset release and while auto_en=0
- vy_init  in  VEL_W  signed y velocity, loaded under the same rules as vx_init
- anim_div  in  ANIM_DIV_W  animation advances every anim_div+1 frames
- ghost_color  in  3  colour field of the ctrl word
- cpu_cs  in  1  CPU slot chip select
- cpu_write  in  1  CPU slot write strobe
- cpu_addr  in  14  CPU slot address
- cpu_wr_data  in  32  CPU slot write data
- spr_cs  out  1  sprite slot chip select
- spr_write  out  1  sprite slot write strobe
- spr_addr  out  14  sprite slot address
- spr_wr_data  out  32  sprite slot write data
- busy  out  1  high whenever the state is not IDLE
- overrun  out  1  sticky flag: a frame_start arrived while busy; cleared when auto_en falls

Behaviour:
- Reset values:
  - All outputs 0.
  - pos_x=0, pos_y=0, anim_frame=0, div_cnt=0, state=IDLE.
  - vx and vy take vx_init and vy_init.
- Bus mux:
  - If cpu_cs&cpu_write, the spr_* outputs equal the cpu_* inputs combinationally, with zero latency.
  - Otherwise the spr_* outputs carry the engine write when the state is WR_X, WR_Y or WR_C; else they are 0.
  - The engine never drops a write. It holds its WR state until a cycle with no CPU write.
- Register map driven (addr[13]=1):
  - addr[1:0]=01 is x0.
  - addr[1:0]=10 is y0.
  - addr[1:0]=11 is ctrl.
  - Data is in the low bits, upper bits 0.
- Coherency:
  - A CPU write to x0 loads pos_x from cpu_wr_data[10:0] in the same cycle; a CPU write to y0 loads pos_y the same way.
  - If this happens in WR_X or WR_Y, the engine writes its already-computed value. That value is overwritten next frame with the CPU position as the base.
- FSM:
  - IDLE: frame_start & auto_en -> CALC.
  - CALC, 1 cycle: registers next positions and velocities -> WR_X.
  - WR_X: issue x0 write on the first free cycle -> WR_Y.
  - WR_Y: issue y0 write on the first free cycle. Go to WR_C if anim_tick, else IDLE.
  - WR_C: write ctrl = {ghost_color, anim_frame}, 5 bits, on the first free cycle -> IDLE.
  - Minimum latency from frame_start to the last write: 3 cycles without animation, 4 with animation.
- Motion arithmetic:
  - 12-bit signed: nx = pos_x + sext(vx).
  - If nx<0: pos_x=0 and vx=-vx.
  - Else if nx>H_MAX-SPRITE_W: pos_x=H_MAX-SPRITE_W and vx=-vx.
  - Else pos_x=nx.
  - Y works identically against V_MAX-SPRITE_W.
  - vx = most-negative value is treated as its negation saturated to the maximum positive value.
- Animation:
  - div_cnt increments in CALC.
  - When div_cnt==anim_div: anim_tick=1, div_cnt clears, and anim_frame increments modulo 4.
- frame_start while not IDLE: the pulse is ignored and overrun is set.
- auto_en low:
  - In IDLE, vx and vy reload from their inputs every cycle.
  - If auto_en falls mid-sequence, the sequence completes normally.
- Asynchronous reset mid-sequence: the FSM returns to IDLE at once and any pending engine write is abandoned.

Decomposition:
- Package ghost_pkg:
  - State enum.
  - Register-offset constants REG_BYPASS=2'b00, REG_X0=2'b01, REG_Y0=2'b10, REG_CTRL=2'b11.
  - Constant REG_SPACE_BIT=13.
- Sub-module ghost_axis_step, instantiated twice (x and y).
  - Combinational: position, velocity, limit in; next position, next velocity out.

Test Plan:
- Basic step: reset, then auto_en=1, vx=+3, vy=+2, anim_div=0, one frame_start. Expect:
  - x0 write with data 3, then y0 write with data 2.
  - Then ctrl write with {color, 2'b01}, each a single spr_write cycle.
  - busy falls after 4 cycles.
- Right-edge bounce: CPU writes x0=622 with vx=+5. Next frame writes x0=624 and vx becomes -5; the following frame writes x0=619.
- Top-edge bounce: y=1, vy=-4. Expect a y0 write of 0, then 4 on the next frame.
- CPU priority: hold cpu_cs&cpu_write high for 3 cycles starting at the WR_X cycle. Expect:
  - spr_* mirrors the CPU for 3 cycles.
  - The engine x0 write appears on cycle 4, with no lost or duplicated write.
- Coherency: while IDLE, CPU writes x0=100 with vx=+1. The next frame's engine x0 write is 101.
- Overrun, reset and divider:
  - frame_start during WR_Y sets overrun; it clears on auto_en=0.
  - reset_n asserted in WR_X gives all spr_* outputs 0 immediately.
  - anim_div=2 produces a ctrl write only on every third frame.
